csr_file: RTL and testbench
===========================

# csr_file

Machine-mode CSR file for the RV32I core. It is the responder on the trap-handling CSR port: it serves the mtvec/mepc reads the trap controller issues and commits the mepc/mcause writes it produces. A second port serves Zicsr instructions from the execute stage. It also owns the free-running cycle and retired-instruction counters.

## Interface
- No parameters.
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- trap_address  input  12  CSR address from the trap controller; used for both read and write
- trap_write_enable  input  1  trap-port write strobe
- trap_write_data  input  32  trap-port write value
- trap_read_data  output  32  value of the CSR at trap_address
- csr_read_address  input  12  instruction-port read address
- csr_read_data  output  32  value of the CSR at csr_read_address
- csr_write_enable  input  1  instruction-port write strobe
- csr_write_address  input  12  instruction-port write address
- csr_write_data  input  32  instruction-port write value (already merged by the ALU for CSRRS/CSRRC)
- retire_valid  input  1  one instruction retired this cycle
- csr_illegal  output  1  instruction-port access is illegal

## Operation
- Implemented CSRs and their reset values:
  - mstatus 0x300: reset 0x0000_1800. Only MIE[3] and MPIE[7] are writable. MPP[12:11] is hardwired to 11.
  - misa 0x301: read-only, 0x4000_0100.
  - mie 0x304: reset 0.
  - mtvec 0x305: reset 0. Bits [1:0] are forced to 0 on write (direct mode only).
  - mscratch 0x340, mcause 0x342, mtval 0x343: reset 0.
  - mepc 0x341: reset 0. Bits [1:0] are cleared on write.
  - mip 0x344: reads 0; writes ignored.
  - mvendorid, marchid, mimpid, mhartid (0xF11–0xF14): read 0.
  - Counters: mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82, with read-only shadows cycle/cycleh/instret/instreth at 0xC00/0xC80/0xC02/0xC82.
- Reads on both ports are combinational from register state. A write becomes visible on the cycle after the clock edge that commits it; there is no write-to-read bypass.
- Unimplemented addresses read 0.
- csr_illegal is combinational and asserts when either holds:
  - csr_read_address is unimplemented;
  - csr_write_enable=1 and csr_write_address[11:10]==2'b11 or is unimplemented.
- An illegal write is dropped. The trap port never flags illegal; its writes to read-only or unimplemented addresses are silently dropped.
- Simultaneous writes:
  - Same address on both ports: the trap port wins and the instruction write is discarded.
  - Different addresses: both commit in the same cycle.
- Counters (when compiled in):
  - mcycle is 64-bit and increments every cycle after reset.
  - minstret is 64-bit and increments when retire_valid=1.
  - Low-to-high carry occurs on wrap from 0xFFFF_FFFF.
- Explicit counter write vs. increment in the same cycle:
  - Write to the low half: the written value is stored, and the high half receives no carry that cycle.
  - Write to the high half: the low half increments normally, the written high value is stored, and any carry is discarded.

## Timing
- All state updates occur on the rising edge of clk.
- rst asserted at any time, including mid-write, immediately forces every register to its reset value. Both read outputs then reflect reset values combinationally; csr_illegal depends only on inputs.
- Trap-controller handshake:
  - mtvec/mepc read: zero-latency. The controller presents trap_address and samples trap_read_data in the same cycle.
  - mepc write followed by a read-back of mepc: the read-back is valid from the next cycle.
- Counters do not increment while rst=1. mcycle reads 0 in the first cycle after rst deasserts, then 1, 2, …

## Configuration
- CSR_COUNTERS_EN defined: the 64-bit mcycle/minstret counters and all eight counter addresses are implemented as described above.
- CSR_COUNTERS_EN undefined: no counter flops are built. The counter addresses read 0, their writes are ignored, and they are not flagged by csr_illegal. retire_valid is unused.

## Test plan
- **Reset values:** rst pulse, then read 0x300, 0x301 and 0x305 → 0x0000_1800, 0x4000_0100, 0. With counters enabled, mcycle reads 0, 1, 2 on successive cycles.
- **Trap-port writes:**
  - Write 0x341=0x0000_1100, then 0x342=11 on the next cycle. trap_read_data at 0x341 = 0x0000_1100 and at 0x342 = 0x0000_000B one cycle after each write.
  - Write 0x341=0x0000_1111; it reads back as 0x0000_1110.
- **Write collision:** trap writes 0x341=0xAAAA_0000 and the instruction port writes 0x341=0x5555_0000 in the same cycle → reads 0xAAAA_0000. Repeat with instruction address 0x340 → both values stored.
- **mcycle wrap:**
  - Write 0xB00=0xFFFF_FFFF with mcycleh=0 → next cycle mcycle=0 and mcycleh=1.
  - Write 0xB00 and 0xB80 in the same cycle via trap and instruction ports → written values held exactly.
- **minstret:** three retire_valid pulses separated by idle cycles → minstret=3 and instret (0xC02) = 3.
- **Illegal accesses:**
  - Read 0x7C0 → csr_illegal=1, data 0.
  - Write 0xF14 or 0xC00 → csr_illegal=1 and the value is unchanged.
  - Trap-port write to 0x301 → misa still reads 0x4000_0100 and csr_illegal stays 0.

Source files
------------

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap-controller port, Zicsr instruction port and 64-bit mcycle/minstret counters.
// Define CSR_COUNTERS_EN to build the counters; otherwise their addresses read 0 and ignore writes.
module csr_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] trap_address,
    input  logic        trap_write_enable,
    input  logic [31:0] trap_write_data,
    output logic [31:0] trap_read_data,
    input  logic [11:0] csr_read_address,
    output logic [31:0] csr_read_data,
    input  logic        csr_write_enable,
    input  logic [11:0] csr_write_address,
    input  logic [31:0] csr_write_data,
    input  logic        retire_valid,
    output logic        csr_illegal
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 12;
    localparam int unsigned CW   = 64;

    localparam logic [AW-1:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [AW-1:0] ADDR_MISA      = 12'h301;
    localparam logic [AW-1:0] ADDR_MIE       = 12'h304;
    localparam logic [AW-1:0] ADDR_MTVEC     = 12'h305;
    localparam logic [AW-1:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [AW-1:0] ADDR_MEPC      = 12'h341;
    localparam logic [AW-1:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [AW-1:0] ADDR_MTVAL     = 12'h343;
    localparam logic [AW-1:0] ADDR_MIP       = 12'h344;
    localparam logic [AW-1:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [AW-1:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [AW-1:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [AW-1:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [AW-1:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [AW-1:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [AW-1:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [AW-1:0] ADDR_INSTRETH  = 12'hC82;

    localparam logic [XLEN-1:0] MSTATUS_FIXED = 32'h0000_1800;
    localparam logic [XLEN-1:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [XLEN-1:0] MISA_VALUE    = 32'h4000_0100;
    localparam logic [XLEN-1:0] ALIGN4_MASK   = 32'hFFFF_FFFC;

`ifdef CSR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    function automatic logic is_counter(input logic [AW-1:0] a);
        case (a)
            ADDR_MCYCLE, ADDR_MCYCLEH, ADDR_MINSTRET, ADDR_MINSTRETH,
            ADDR_CYCLE, ADDR_CYCLEH, ADDR_INSTRET, ADDR_INSTRETH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_impl(input logic [AW-1:0] a);
        case (a)
            ADDR_MSTATUS, ADDR_MISA, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH,
            ADDR_MEPC, ADDR_MCAUSE, ADDR_MTVAL, ADDR_MIP,
            12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
            default: return is_counter(a);
        endcase
    endfunction

    // Winning write for one address: {hit, data}; trap port takes priority
    function automatic logic [XLEN:0] wsel(
        input logic [AW-1:0]   a,
        input logic            t_en,
        input logic [AW-1:0]   t_a,
        input logic [XLEN-1:0] t_d,
        input logic            i_en,
        input logic [AW-1:0]   i_a,
        input logic [XLEN-1:0] i_d
    );
        if (t_en && (t_a == a)) return {1'b1, t_d};
        if (i_en && (i_a == a)) return {1'b1, i_d};
        return '0;
    endfunction

    logic [XLEN-1:0] mstatus_q;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;

    logic inst_wr_ok;
    logic [XLEN:0] w_mstatus, w_mie, w_mtvec, w_mscratch, w_mepc, w_mcause, w_mtval;

    // Counter addresses are never flagged when the counters are not built
    always_comb begin
        csr_illegal = 1'b0;
        if (!is_impl(csr_read_address)) begin
            csr_illegal = 1'b1;
        end
        if (csr_write_enable) begin
            if (!is_impl(csr_write_address)) begin
                csr_illegal = 1'b1;
            end else if ((csr_write_address[11:10] == 2'b11) &&
                         (CNT_EN || !is_counter(csr_write_address))) begin
                csr_illegal = 1'b1;
            end
        end
    end

    assign inst_wr_ok = csr_write_enable && !csr_illegal &&
                        !(trap_write_enable && (trap_address == csr_write_address));

    assign w_mstatus  = wsel(ADDR_MSTATUS,  trap_write_enable, trap_address, trap_write_data,
                             inst_wr_ok, csr_write_address, csr_write_data);
    assign w_mie      = wsel(ADDR_MIE,      trap_write_enable, trap_address, trap_write_data,
                             inst_wr_ok, csr_write_address, csr_write_data);
    assign w_mtvec    = wsel(ADDR_MTVEC,    trap_write_enable, trap_address, trap_write_data,
                             inst_wr_ok, csr_write_address, csr_write_data);
    assign w_mscratch = wsel(ADDR_MSCRATCH, trap_write_enable, trap_address, trap_write_data,
                             inst_wr_ok, csr_write_address, csr_write_data);
    assign w_mepc     = wsel(ADDR_MEPC,     trap_write_enable, trap_address, trap_write_data,
                             inst_wr_ok, csr_write_address, csr_write_data);
    assign w_mcause   = wsel(ADDR_MCAUSE,   trap_write_enable, trap_address, trap_write_data,
                             inst_wr_ok, csr_write_address, csr_write_data);
    assign w_mtval    = wsel(ADDR_MTVAL,    trap_write_enable, trap_address, trap_write_data,
                             inst_wr_ok, csr_write_address, csr_write_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            if (w_mstatus[XLEN])  mstatus_q  <= w_mstatus[XLEN-1:0] & MSTATUS_WMASK;
            if (w_mie[XLEN])      mie_q      <= w_mie[XLEN-1:0];
            if (w_mtvec[XLEN])    mtvec_q    <= w_mtvec[XLEN-1:0] & ALIGN4_MASK;
            if (w_mscratch[XLEN]) mscratch_q <= w_mscratch[XLEN-1:0];
            if (w_mepc[XLEN])     mepc_q     <= w_mepc[XLEN-1:0] & ALIGN4_MASK;
            if (w_mcause[XLEN])   mcause_q   <= w_mcause[XLEN-1:0];
            if (w_mtval[XLEN])    mtval_q    <= w_mtval[XLEN-1:0];
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [CW-1:0] mcycle_q, minstret_q;
    logic [CW-1:0] mcycle_inc, minstret_inc;
    logic [XLEN:0] w_mcycle, w_mcycleh, w_minstret, w_minstreth;

    assign w_mcycle    = wsel(ADDR_MCYCLE,    trap_write_enable, trap_address, trap_write_data,
                              inst_wr_ok, csr_write_address, csr_write_data);
    assign w_mcycleh   = wsel(ADDR_MCYCLEH,   trap_write_enable, trap_address, trap_write_data,
                              inst_wr_ok, csr_write_address, csr_write_data);
    assign w_minstret  = wsel(ADDR_MINSTRET,  trap_write_enable, trap_address, trap_write_data,
                              inst_wr_ok, csr_write_address, csr_write_data);
    assign w_minstreth = wsel(ADDR_MINSTRETH, trap_write_enable, trap_address, trap_write_data,
                              inst_wr_ok, csr_write_address, csr_write_data);

    assign mcycle_inc   = mcycle_q + CW'(1);
    assign minstret_inc = minstret_q + CW'(retire_valid);

    // A low-half write suppresses the carry; a high-half write discards it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q[XLEN-1:0]    <= w_mcycle[XLEN] ? w_mcycle[XLEN-1:0] : mcycle_inc[XLEN-1:0];
            mcycle_q[CW-1:XLEN]   <= w_mcycleh[XLEN] ? w_mcycleh[XLEN-1:0] :
                                     w_mcycle[XLEN]  ? mcycle_q[CW-1:XLEN] : mcycle_inc[CW-1:XLEN];
            minstret_q[XLEN-1:0]  <= w_minstret[XLEN] ? w_minstret[XLEN-1:0] : minstret_inc[XLEN-1:0];
            minstret_q[CW-1:XLEN] <= w_minstreth[XLEN] ? w_minstreth[XLEN-1:0] :
                                     w_minstret[XLEN]  ? minstret_q[CW-1:XLEN] : minstret_inc[CW-1:XLEN];
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire_valid;
`endif

    function automatic logic [XLEN-1:0] read_csr(input logic [AW-1:0] a);
        case (a)
            ADDR_MSTATUS:  return mstatus_q | MSTATUS_FIXED;
            ADDR_MISA:     return MISA_VALUE;
            ADDR_MIE:      return mie_q;
            ADDR_MTVEC:    return mtvec_q;
            ADDR_MSCRATCH: return mscratch_q;
            ADDR_MEPC:     return mepc_q;
            ADDR_MCAUSE:   return mcause_q;
            ADDR_MTVAL:    return mtval_q;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE,    ADDR_CYCLE:    return mcycle_q[XLEN-1:0];
            ADDR_MCYCLEH,   ADDR_CYCLEH:   return mcycle_q[CW-1:XLEN];
            ADDR_MINSTRET,  ADDR_INSTRET:  return minstret_q[XLEN-1:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: return minstret_q[CW-1:XLEN];
`endif
            default:       return '0;
        endcase
    endfunction

    always_comb begin
        trap_read_data = read_csr(trap_address);
        csr_read_data  = read_csr(csr_read_address);
    end

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: directed scenarios plus randomized traffic against a behavioural CSR model.
module tb_csr_file;

`ifdef CSR_COUNTERS_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] trap_address = '0;
    logic        trap_write_enable = 1'b0;
    logic [31:0] trap_write_data = '0;
    logic [31:0] trap_read_data;
    logic [11:0] csr_read_address = 12'h300;
    logic [31:0] csr_read_data;
    logic        csr_write_enable = 1'b0;
    logic [11:0] csr_write_address = 12'h300;
    logic [31:0] csr_write_data = '0;
    logic        retire_valid = 1'b0;
    logic        csr_illegal;

    csr_file dut (
        .clk(clk), .rst(rst),
        .trap_address(trap_address), .trap_write_enable(trap_write_enable),
        .trap_write_data(trap_write_data), .trap_read_data(trap_read_data),
        .csr_read_address(csr_read_address), .csr_read_data(csr_read_data),
        .csr_write_enable(csr_write_enable), .csr_write_address(csr_write_address),
        .csr_write_data(csr_write_data), .retire_valid(retire_valid),
        .csr_illegal(csr_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] t;
        logic [31:0] c;
        logic        i;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: architectural register values and 64-bit counters
    logic [31:0]     mreg [0:4095];
    longint unsigned mcyc, mins;

    function automatic bit is_cnt(logic [11:0] a);
        return a inside {12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82};
    endfunction

    function automatic bit impl(logic [11:0] a);
        return is_cnt(a) || (a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                      12'h342, 12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14});
    endfunction

    function automatic bit m_illegal(logic [11:0] ra, bit we, logic [11:0] wa);
        bit ro;
        ro = (wa[11:10] == 2'b11) && !(!CNT && is_cnt(wa));
        return !impl(ra) || (we && (!impl(wa) || ro));
    endfunction

    function automatic logic [31:0] mread(logic [11:0] a);
        case (a)
            12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343: return mreg[a];
            12'h301: return 32'h4000_0100;
            12'hB00, 12'hC00: return CNT ? mcyc[31:0] : 32'h0;
            12'hB80, 12'hC80: return CNT ? mcyc[63:32] : 32'h0;
            12'hB02, 12'hC02: return CNT ? mins[31:0] : 32'h0;
            12'hB82, 12'hC82: return CNT ? mins[63:32] : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void mreset();
        foreach (mreg[k]) mreg[k] = 32'h0;
        mreg[12'h300] = 32'h0000_1800;
        mcyc = 0;
        mins = 0;
    endfunction

    function automatic void mstore(logic [11:0] a, logic [31:0] d);
        case (a)
            12'h300: mreg[a] = 32'h0000_1800 | (d & 32'h0000_0088);
            12'h304, 12'h340, 12'h342, 12'h343: mreg[a] = d;
            12'h305, 12'h341: mreg[a] = {d[31:2], 2'b00};
            default: ;
        endcase
    endfunction

    function automatic bit whit(logic [11:0] a, logic [11:0] ta, bit twe, logic [31:0] twd,
                                bit iok, logic [11:0] wa, logic [31:0] wd, output logic [31:0] d);
        d = 32'h0;
        if (twe && ta == a) begin d = twd; return 1'b1; end
        if (iok && wa == a) begin d = wd; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic longint unsigned cnt_next(longint unsigned old, int unsigned amt,
                                                 bit hl, logic [31:0] dl, bit hh, logic [31:0] dh);
        logic [63:0] o, n;
        logic [31:0] lo, hi;
        o  = old;
        n  = old + amt;
        lo = hl ? dl : n[31:0];
        hi = hh ? dh : (hl ? o[63:32] : n[63:32]);
        return {hi, lo};
    endfunction

    function automatic void mcommit(logic [11:0] ta, bit twe, logic [31:0] twd, logic [11:0] ra,
                                    bit cwe, logic [11:0] wa, logic [31:0] wd, bit rv);
        bit iok, hl, hh;
        logic [31:0] dl, dh;
        iok = cwe && !m_illegal(ra, cwe, wa) && !(twe && ta == wa);
        if (CNT) begin
            hl = whit(12'hB00, ta, twe, twd, iok, wa, wd, dl);
            hh = whit(12'hB80, ta, twe, twd, iok, wa, wd, dh);
            mcyc = cnt_next(mcyc, 1, hl, dl, hh, dh);
            hl = whit(12'hB02, ta, twe, twd, iok, wa, wd, dl);
            hh = whit(12'hB82, ta, twe, twd, iok, wa, wd, dh);
            mins = cnt_next(mins, rv ? 1 : 0, hl, dl, hh, dh);
        end
        if (iok) mstore(wa, wd);
        if (twe) mstore(ta, twd);
    endfunction

    // One cycle of stimulus; cm selects which fields use the given constants instead of the model
    task automatic cyc(input bit r, input logic [11:0] ta, input bit twe, input logic [31:0] twd,
                       input logic [11:0] ra, input bit cwe, input logic [11:0] wa, input logic [31:0] wd,
                       input bit rv, input logic [2:0] cm, input logic [31:0] et, input logic [31:0] ec,
                       input bit ei, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        trap_address = ta; trap_write_enable = twe; trap_write_data = twd;
        csr_read_address = ra; csr_write_enable = cwe; csr_write_address = wa; csr_write_data = wd;
        retire_valid = rv;
        if (r) mreset();
        e.name = name;
        e.t = cm[2] ? et : mread(ta);
        e.c = cm[1] ? ec : mread(ra);
        e.i = cm[0] ? ei : m_illegal(ra, cwe, wa);
        q.push_back(e);
        if (!r) mcommit(ta, twe, twd, ra, cwe, wa, wd, rv);
    endtask

    task automatic tw(input logic [11:0] ta, input logic [31:0] d, input string name);
        cyc(1'b0, ta, 1'b1, d, 12'h300, 1'b0, 12'h300, 32'h0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, name);
    endtask

    task automatic chk(input logic [11:0] ta, input logic [31:0] et, input logic [11:0] ra,
                       input logic [31:0] ec, input bit ei, input string name);
        cyc(1'b0, ta, 1'b0, 32'h0, ra, 1'b0, ra, 32'h0, 1'b0, 3'b111, et, ec, ei, name);
    endtask

    task automatic ret(input bit rv);
        cyc(1'b0, 12'h300, 1'b0, 32'h0, 12'h300, 1'b0, 12'h300, 32'h0, rv, 3'b000, 32'h0, 32'h0, 1'b0, "retire");
    endtask

    // Monitor: compare the outputs of each issued cycle mid-cycle
    exp_t me;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            n_tests += 3;
            if (trap_read_data !== me.t) begin
                n_fail++;
                $display("FAIL %s trap_read_data: got %h expected %h", me.name, trap_read_data, me.t);
            end
            if (csr_read_data !== me.c) begin
                n_fail++;
                $display("FAIL %s csr_read_data: got %h expected %h", me.name, csr_read_data, me.c);
            end
            if (csr_illegal !== me.i) begin
                n_fail++;
                $display("FAIL %s csr_illegal: got %b expected %b", me.name, csr_illegal, me.i);
            end
        end
    end

    logic [11:0] pool [$];
    logic [11:0] ipool [$];

    initial begin
        logic [11:0] ta, ra, wa;
        bit twe, cwe, rv, r;
        logic [31:0] twd, wd;

        mreset();
        cyc(1'b1, 12'h300, 1'b0, 32'h0, 12'h301, 1'b0, 12'h301, 32'h0, 1'b0, 3'b111,
            32'h0000_1800, 32'h4000_0100, 1'b0, "reset_hold");
        cyc(1'b1, 12'h305, 1'b0, 32'h0, 12'h300, 1'b0, 12'h300, 32'h0, 1'b0, 3'b111,
            32'h0, 32'h0000_1800, 1'b0, "reset_hold2");
        chk(12'h300, 32'h0000_1800, 12'hB00, 32'h0, 1'b0, "mcycle0");
        chk(12'h301, 32'h4000_0100, 12'hB00, CNT ? 32'd1 : 32'd0, 1'b0, "mcycle1");
        chk(12'h305, 32'h0, 12'hB00, CNT ? 32'd2 : 32'd0, 1'b0, "mcycle2");

        tw(12'h341, 32'h0000_1100, "wr_mepc");
        cyc(1'b0, 12'h342, 1'b1, 32'd11, 12'h341, 1'b0, 12'h341, 32'h0, 1'b0, 3'b010,
            32'h0, 32'h0000_1100, 1'b0, "mepc_rb");
        chk(12'h342, 32'h0000_000B, 12'h341, 32'h0000_1100, 1'b0, "mcause_rb");
        tw(12'h341, 32'h0000_1111, "wr_mepc_odd");
        chk(12'h341, 32'h0000_1110, 12'h300, 32'h0000_1800, 1'b0, "mepc_align");

        cyc(1'b0, 12'h341, 1'b1, 32'hAAAA_0000, 12'h341, 1'b1, 12'h341, 32'h5555_0000, 1'b0, 3'b001,
            32'h0, 32'h0, 1'b0, "collide_same");
        chk(12'h341, 32'hAAAA_0000, 12'h341, 32'hAAAA_0000, 1'b0, "collide_same_rb");
        cyc(1'b0, 12'h341, 1'b1, 32'hAAAA_0000, 12'h340, 1'b1, 12'h340, 32'h5555_0000, 1'b0, 3'b001,
            32'h0, 32'h0, 1'b0, "collide_diff");
        chk(12'h341, 32'hAAAA_0000, 12'h340, 32'h5555_0000, 1'b0, "collide_diff_rb");

        tw(12'hB80, 32'h0, "wr_mcycleh");
        tw(12'hB00, 32'hFFFF_FFFF, "wr_mcycle");
        chk(12'hB00, CNT ? 32'hFFFF_FFFF : 32'h0, 12'hB80, 32'h0, 1'b0, "mcycle_pre_wrap");
        chk(12'hB00, 32'h0, 12'hB80, CNT ? 32'd1 : 32'd0, 1'b0, "mcycle_wrap");
        cyc(1'b0, 12'hB00, 1'b1, 32'h1234_5678, 12'hB80, 1'b1, 12'hB80, 32'h9ABC_DEF0, 1'b0, 3'b001,
            32'h0, 32'h0, 1'b0, "cnt_dual_wr");
        chk(12'hB00, CNT ? 32'h1234_5678 : 32'h0, 12'hB80, CNT ? 32'h9ABC_DEF0 : 32'h0, 1'b0, "cnt_dual_rb");

        cyc(1'b0, 12'hB02, 1'b1, 32'h0, 12'hB82, 1'b1, 12'hB82, 32'h0, 1'b0, 3'b001,
            32'h0, 32'h0, 1'b0, "minstret_clr");
        ret(1'b1); ret(1'b0); ret(1'b1); ret(1'b0); ret(1'b1); ret(1'b0);
        chk(12'hB02, CNT ? 32'd3 : 32'd0, 12'hC02, CNT ? 32'd3 : 32'd0, 1'b0, "minstret3");

        chk(12'h300, 32'h0000_1800, 12'h7C0, 32'h0, 1'b1, "illegal_read");
        cyc(1'b0, 12'h300, 1'b0, 32'h0, 12'hF14, 1'b1, 12'hF14, 32'h5, 1'b0, 3'b011,
            32'h0, 32'h0, 1'b1, "illegal_wr_f14");
        chk(12'h300, 32'h0000_1800, 12'hF14, 32'h0, 1'b0, "f14_unchanged");
        if (CNT) begin
            cyc(1'b0, 12'hB00, 1'b0, 32'h0, 12'hC00, 1'b1, 12'hC00, 32'h0, 1'b0, 3'b001,
                32'h0, 32'h0, 1'b1, "illegal_wr_c00");
            cyc(1'b0, 12'hB00, 1'b0, 32'h0, 12'hC00, 1'b0, 12'hC00, 32'h0, 1'b0, 3'b000,
                32'h0, 32'h0, 1'b0, "c00_unchanged");
        end
        cyc(1'b0, 12'h301, 1'b1, 32'h0, 12'h300, 1'b0, 12'h300, 32'h0, 1'b0, 3'b001,
            32'h0, 32'h0, 1'b0, "trap_wr_misa");
        chk(12'h301, 32'h4000_0100, 12'h300, 32'h0000_1800, 1'b0, "misa_kept");

        ipool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                  12'hF11, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82};
        pool = ipool;
        pool.push_back(12'h7C0);
        pool.push_back(12'h123);
        pool.push_back(12'h3A0);

        for (int k = 0; k < 400; k++) begin
            ta  = pool[$urandom_range(0, pool.size() - 1)];
            wa  = pool[$urandom_range(0, pool.size() - 1)];
            if ($urandom_range(0, 3) == 0) wa = ta;
            twe = ($urandom_range(0, 2) == 0);
            cwe = ($urandom_range(0, 2) == 0);
            ra  = cwe ? ipool[$urandom_range(0, ipool.size() - 1)] : pool[$urandom_range(0, pool.size() - 1)];
            twd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            wd  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            rv  = ($urandom_range(0, 1) == 1);
            r   = ($urandom_range(0, 99) == 0);
            cyc(r, ta, twe, twd, ra, cwe, wa, wd, rv, 3'b000, 32'h0, 32'h0, 1'b0, "random");
        end

        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
